// File: rtl/fx_kport_pkg.sv
// Shared definitions for the PC-FX K-port pad emulation: states, button map,
// device IDs and the transmit-word builder.
package fx_kport_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_LATCHED,
      ST_SHIFT_OUT,
      ST_SHIFT_IN,
      ST_DONE
   } kport_state_t;

   localparam int unsigned KP_WORD_BITS = 32;

   localparam logic [3:0] KP_ID_PAD  = 4'hF;
   localparam logic [3:0] KP_ID_NONE = 4'h0;

   localparam int unsigned KP_BTN_I      = 0;
   localparam int unsigned KP_BTN_II     = 1;
   localparam int unsigned KP_BTN_III    = 2;
   localparam int unsigned KP_BTN_IV     = 3;
   localparam int unsigned KP_BTN_V      = 4;
   localparam int unsigned KP_BTN_VI     = 5;
   localparam int unsigned KP_BTN_SELECT = 6;
   localparam int unsigned KP_BTN_RUN    = 7;
   localparam int unsigned KP_BTN_UP     = 8;
   localparam int unsigned KP_BTN_RIGHT  = 9;
   localparam int unsigned KP_BTN_DOWN   = 10;
   localparam int unsigned KP_BTN_LEFT   = 11;
   localparam int unsigned KP_BTN_MODE1  = 12;
   localparam int unsigned KP_BTN_RSVD0  = 13;
   localparam int unsigned KP_BTN_MODE2  = 14;
   localparam int unsigned KP_BTN_RSVD1  = 15;

   // Bits 13 and 15 are not wired on a real pad and always read as 0.
   localparam logic [15:0] KP_BTN_MASK =
      ~((16'h0001 << KP_BTN_RSVD0) | (16'h0001 << KP_BTN_RSVD1));

   function automatic logic [31:0] kp_pad_word(input logic [3:0]  id,
                                                input logic [15:0] buttons);
      return {id, 12'h000, buttons & KP_BTN_MASK};
   endfunction

endpackage

// File: rtl/fx_kport_edge.sv
// Registered rise/fall detector with clock enable; history follows the input
// level during reset so no spurious edge appears when reset is released.
module fx_kport_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic ce,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic prev_q;
   logic prev_d;

   always_comb begin
      prev_d = din;
   end

   always_ff @(posedge clk) begin
      if (ce) begin
         if (!rst_n) begin
            prev_q <= din;
         end else begin
            prev_q <= prev_d;
         end
      end
   end

   assign rise = din & ~prev_q;
   assign fall = ~din & prev_q;

endmodule

// File: rtl/fx_kport_pad.sv
// Pad-side end of the PC-FX K-port: snapshots buttons on latch, shifts the
// ID+button word out LSB first, and captures host-written words.
module fx_kport_pad
   import fx_kport_pkg::*;
#(
   parameter logic [3:0]  PAD_ID    = KP_ID_PAD,
   parameter int unsigned WORD_BITS = KP_WORD_BITS
) (
   input  logic        CLK,
   input  logic        RESn,
   input  logic        CE,
   input  logic        KP_LATCH,
   input  logic        KP_CLK,
   input  logic        KP_RW,
   input  logic        KP_DOUT,
   output logic        KP_DIN,
   input  logic        CONNECTED,
   input  logic [15:0] BUTTONS,
   output logic [31:0] RX_DATA,
   output logic        RX_VALID,
   output logic        BUSY
);

   localparam int unsigned CW = $clog2(WORD_BITS + 1);
   localparam logic [CW-1:0] LAST_COUNT = CW'(WORD_BITS);

   kport_state_t         state_q, state_d;
   logic [WORD_BITS-1:0] tx_sr_q, tx_sr_d;
   logic [WORD_BITS-1:0] rx_sr_q, rx_sr_d;
   logic [WORD_BITS-1:0] rx_data_q, rx_data_d;
   logic [CW-1:0]        count_q, count_d;
   logic [CW-1:0]        count_inc;
   logic                 rx_valid_q, rx_valid_d;
   logic                 kp_din_q, kp_din_d;

   logic latch_rise, latch_fall;
   logic clk_rise, clk_fall;

   fx_kport_edge u_latch_edge (
      .clk   (CLK),
      .rst_n (RESn),
      .ce    (CE),
      .din   (KP_LATCH),
      .rise  (latch_rise),
      .fall  (latch_fall)
   );

   fx_kport_edge u_clk_edge (
      .clk   (CLK),
      .rst_n (RESn),
      .ce    (CE),
      .din   (KP_CLK),
      .rise  (clk_rise),
      .fall  (clk_fall)
   );

   always_ff @(posedge CLK) begin
      if (CE) begin
         if (!RESn) begin
            state_q    <= ST_IDLE;
            tx_sr_q    <= '0;
            rx_sr_q    <= '0;
            rx_data_q  <= '0;
            count_q    <= '0;
            rx_valid_q <= 1'b0;
            kp_din_q   <= 1'b0;
         end else begin
            state_q    <= state_d;
            tx_sr_q    <= tx_sr_d;
            rx_sr_q    <= rx_sr_d;
            rx_data_q  <= rx_data_d;
            count_q    <= count_d;
            rx_valid_q <= rx_valid_d;
            kp_din_q   <= kp_din_d;
         end
      end
   end

   assign count_inc = count_q + CW'(1);

   // Latch rise takes priority everywhere; serial clock edges count only while latch is low.
   always_comb begin
      state_d    = state_q;
      tx_sr_d    = tx_sr_q;
      rx_sr_d    = rx_sr_q;
      rx_data_d  = rx_data_q;
      count_d    = count_q;
      rx_valid_d = 1'b0;

      if (latch_rise) begin
         state_d = ST_LATCHED;
         tx_sr_d = WORD_BITS'(kp_pad_word(PAD_ID, BUTTONS));
         count_d = '0;
      end else begin
         case (state_q)
            ST_LATCHED: begin
               if (latch_fall) begin
                  state_d = KP_RW ? ST_SHIFT_OUT : ST_SHIFT_IN;
               end
            end
            ST_SHIFT_OUT: begin
               if (clk_fall && !KP_LATCH) begin
                  tx_sr_d = {1'b1, tx_sr_q[WORD_BITS-1:1]};
                  count_d = count_inc;
                  if (count_inc == LAST_COUNT) begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_SHIFT_IN: begin
               if (clk_rise && !KP_LATCH) begin
                  rx_sr_d = {KP_DOUT, rx_sr_q[WORD_BITS-1:1]};
                  count_d = count_inc;
                  if (count_inc == LAST_COUNT) begin
                     rx_data_d  = rx_sr_d;
                     rx_valid_d = 1'b1;
                     state_d    = ST_DONE;
                  end
               end
            end
            default: begin
            end
         endcase
      end
   end

   // KP_DIN is registered from the next state so it tracks the state register exactly.
   always_comb begin
      kp_din_d = 1'b1;
      case (state_d)
         ST_LATCHED, ST_SHIFT_OUT: kp_din_d = tx_sr_d[0];
         default:                  kp_din_d = 1'b1;
      endcase
      if (!CONNECTED) begin
         kp_din_d = 1'b0;
      end
   end

   assign KP_DIN   = kp_din_q;
   assign RX_DATA  = rx_data_q;
   assign RX_VALID = rx_valid_q;
   assign BUSY     = (state_q == ST_LATCHED) || (state_q == ST_SHIFT_OUT) ||
                     (state_q == ST_SHIFT_IN);

endmodule

// File: tb/tb_fx_kport_pad.sv
// Directed bench for fx_kport_pad: table of read vectors plus hand-written
// write, re-latch, over-clock, reset and clock-enable sequences.
module tb_fx_kport_pad;

   logic        clk;
   logic        resn;
   logic        ce;
   logic        kp_latch;
   logic        kp_clk;
   logic        kp_rw;
   logic        kp_dout;
   logic        kp_din;
   logic        connected;
   logic [15:0] buttons;
   logic [31:0] rx_data;
   logic        rx_valid;
   logic        busy;

   int unsigned n_checks;
   int unsigned n_pass;
   int unsigned half;
   int unsigned ce_mode;
   int unsigned valid_cnt;

   typedef struct {
      logic [15:0] buttons;
      logic        connected;
      logic [31:0] exp_word;
      logic        exp_din_done;
   } read_vec_t;

   read_vec_t vecs [6];

   fx_kport_pad #(
      .PAD_ID    (4'hF),
      .WORD_BITS (32)
   ) dut (
      .CLK       (clk),
      .RESn      (resn),
      .CE        (ce),
      .KP_LATCH  (kp_latch),
      .KP_CLK    (kp_clk),
      .KP_RW     (kp_rw),
      .KP_DOUT   (kp_dout),
      .KP_DIN    (kp_din),
      .CONNECTED (connected),
      .BUTTONS   (buttons),
      .RX_DATA   (rx_data),
      .RX_VALID  (rx_valid),
      .BUSY      (busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Clock-enable pattern: 0 = always on, 1 = one cycle in three, 2 = held off.
   initial begin
      int unsigned phase;
      phase = 0;
      ce = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         phase = (phase + 1) % 3;
         case (ce_mode)
            0:       ce = 1'b1;
            1:       ce = (phase == 0);
            default: ce = 1'b0;
         endcase
      end
   end

   initial begin
      valid_cnt = 0;
      forever begin
         @(negedge clk);
         if (rx_valid) valid_cnt++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, got %0d/%0d checks", n_pass, n_checks);
      $fatal(1, "timeout");
   end

   task automatic tick(input int unsigned n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
      n_checks++;
      if (actual === expected) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic host_latch(input logic rw);
      kp_rw    = rw;
      kp_latch = 1'b1;
      tick(half);
      kp_latch = 1'b0;
      tick(half);
   endtask

   // One host clock pulse per bit: read sampled at the rising edge, write data set with it.
   task automatic host_bits(input int unsigned n, input logic [63:0] txw, output logic [63:0] rxw);
      rxw = '0;
      for (int unsigned i = 0; i < n; i++) begin
         kp_dout = txw[i];
         rxw[i]  = kp_din;
         kp_clk  = 1'b1;
         tick(half);
         kp_clk  = 1'b0;
         tick(half);
      end
   endtask

   initial begin
      logic [63:0] w;
      n_checks  = 0;
      n_pass    = 0;
      half      = 3;
      ce_mode   = 0;
      resn      = 1'b0;
      kp_latch  = 1'b0;
      kp_clk    = 1'b0;
      kp_rw     = 1'b1;
      kp_dout   = 1'b0;
      connected = 1'b1;
      buttons   = 16'h0000;

      vecs[0] = '{16'h0081, 1'b1, 32'hF0000081, 1'b1};
      vecs[1] = '{16'h0081, 1'b0, 32'h00000000, 1'b0};
      vecs[2] = '{16'hFFFF, 1'b1, 32'hF0005FFF, 1'b1};
      vecs[3] = '{16'h0000, 1'b1, 32'hF0000000, 1'b1};
      vecs[4] = '{16'hA000, 1'b1, 32'hF0000000, 1'b1};
      vecs[5] = '{16'h5F00, 1'b1, 32'hF0005F00, 1'b1};

      tick(3);
      check("reset_din",      64'(kp_din),   64'h0);
      check("reset_busy",     64'(busy),     64'h0);
      check("reset_rx_valid", 64'(rx_valid), 64'h0);
      check("reset_rx_data",  64'(rx_data),  64'h0);
      resn = 1'b1;
      tick(2);
      check("idle_din", 64'(kp_din), 64'h1);

      foreach (vecs[k]) begin
         buttons   = vecs[k].buttons;
         connected = vecs[k].connected;
         host_latch(1'b1);
         check("read_busy", 64'(busy), 64'h1);
         host_bits(32, '0, w);
         check("read_word", w, 64'(vecs[k].exp_word));
         check("read_done_din",  64'(kp_din), 64'(vecs[k].exp_din_done));
         check("read_done_busy", 64'(busy),   64'h0);
      end
      connected = 1'b1;

      valid_cnt = 0;
      host_latch(1'b0);
      host_bits(32, 64'hA5C30F12, w);
      tick(2);
      check("write_rx_data",   64'(rx_data), 64'hA5C30F12);
      check("write_valid_cnt", 64'(valid_cnt), 64'h1);
      check("write_busy",      64'(busy), 64'h0);

      valid_cnt = 0;
      host_latch(1'b0);
      host_bits(32, 64'h80000001, w);
      tick(2);
      check("write2_rx_data",   64'(rx_data), 64'h80000001);
      check("write2_valid_cnt", 64'(valid_cnt), 64'h1);

      buttons = 16'h0081;
      host_latch(1'b1);
      host_bits(10, '0, w);
      check("relatch_first10", w, 64'h081);
      buttons = 16'h0100;
      host_latch(1'b1);
      host_bits(32, '0, w);
      check("relatch_word", w, 64'hF0000100);

      buttons = 16'h0081;
      host_latch(1'b1);
      host_bits(40, '0, w);
      check("overclock_word", w, 64'hFF_F0000081);
      check("overclock_busy", 64'(busy), 64'h0);

      host_latch(1'b1);
      host_bits(5, '0, w);
      check("pre_reset_busy", 64'(busy), 64'h1);
      resn = 1'b0;
      tick(1);
      check("midreset_din",  64'(kp_din), 64'h0);
      check("midreset_busy", 64'(busy),   64'h0);
      resn = 1'b1;
      tick(1);
      check("post_reset_idle_din", 64'(kp_din),  64'h1);
      check("post_reset_rx_data",  64'(rx_data), 64'h0);

      buttons = 16'h0081;
      host_latch(1'b1);
      check("ce_bit0", 64'(kp_din), 64'h1);
      ce_mode = 2;
      tick(2);
      kp_clk = 1'b1;
      tick(4);
      kp_clk = 1'b0;
      tick(4);
      ce_mode = 0;
      tick(2);
      check("ce_hold_no_shift", 64'(kp_din), 64'h1);
      check("ce_hold_busy",     64'(busy),   64'h1);
      host_bits(32, '0, w);
      check("ce_hold_word", w, 64'hF0000081);

      ce_mode = 1;
      half    = 4;
      tick(3);
      buttons = 16'h0F0F;
      host_latch(1'b1);
      host_bits(32, '0, w);
      check("ce_third_word", w, 64'hF0000F0F);
      tick(4);
      check("ce_third_busy", 64'(busy), 64'h0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
